ysyx_23060236_regfile_sb: RTL and testbench

Parametrised integer register file with N combinational read ports, one write-back port, write-to-read bypass and a per-register pending-write scoreboard. It sits between decode/issue and write-back in the pipelined core. Issue marks destination registers pending, write-back retires them, and readers get data plus a busy flag for hazard stall. Register 0 is hard-wired to zero and never pending.

---
 rtl/ysyx_23060236_regfile_sb_pkg.sv | 9 +
 rtl/ysyx_23060236_pend_cnt.sv | 45 ++++
 rtl/ysyx_23060236_regfile_sb.sv | 99 +++++++++
 tb/tb_ysyx_23060236_regfile_sb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file.
package ysyx_23060236_regfile_sb_pkg;

  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefPendW     = 2;
  localparam int unsigned DefNread     = 2;

endpackage

// File: rtl/ysyx_23060236_pend_cnt.sv
// Saturating pending-write counter for one register: issue increments, write-back decrements.
module ysyx_23060236_pend_cnt
  import ysyx_23060236_regfile_sb_pkg::*;
#(
  parameter int unsigned PEND_W = DefPendW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt,
  output logic              busy,
  output logic              underflow
);

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic              dec_ok;

  always_comb begin
    dec_ok = dec && (cnt_q != '0);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec_ok && !(&cnt_q)) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec_ok && !inc) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  // Busy reflects the post-update value so a same-cycle issue stalls readers at once.
  assign busy      = (cnt_d != '0);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/ysyx_23060236_regfile_sb.sv
// Register file with N combinational read ports, one write port, optional bypass
// and a per-register pending-write scoreboard.
module ysyx_23060236_regfile_sb
  import ysyx_23060236_regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NREAD      = DefNread,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned PEND_W     = DefPendW
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  output logic                        iss_ready,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        flush,
  output logic                        err
);

  localparam int unsigned NReg = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]         rf_q [NReg];
  logic [NReg-1:0][PEND_W-1:0]   pend;
  logic [NReg-1:0]               busy;
  logic [NReg-1:0]               underflow;
  logic [PEND_W-1:0]             iss_pend;
  logic                          err_q;

  assign pend[0]      = '0;
  assign busy[0]      = 1'b0;
  assign underflow[0] = 1'b0;

  // A same-cycle retire to the saturated register frees a slot for the new issue.
  assign iss_pend  = pend[iss_rd];
  assign iss_ready = !(iss_valid && (iss_rd != '0) && (&iss_pend) &&
                       !(wen && (waddr == iss_rd)));

  for (genvar r = 1; r < NReg; r++) begin : g_pend
    ysyx_23060236_pend_cnt #(
      .PEND_W(PEND_W)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .inc      (iss_valid && iss_ready && (iss_rd == ADDR_WIDTH'(r))),
      .dec      (wen && (waddr == ADDR_WIDTH'(r))),
      .clr      (flush),
      .cnt      (pend[r]),
      .busy     (busy[r]),
      .underflow(underflow[r])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NReg; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      rf_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|underflow) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = rf_q[ra];
      if (ra == '0) begin
        rd = '0;
      end else if ((BYPASS != 0) && wen && (waddr == ra)) begin
        rd = wdata;
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[i] = !reset && busy[ra];
  end

endmodule

// File: tb/tb_ysyx_23060236_regfile_sb.sv
// Bench for the scoreboarded register file: bypass and no-bypass instances share stimulus
// and are compared every cycle against an array-based reference model.
module tb_ysyx_23060236_regfile_sb;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NR   = 2;
  localparam int PW   = 2;
  localparam int NREG = 16;
  localparam int PMAX = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR*AW-1:0]  raddr;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              flush;

  logic [NR*DW-1:0]  rdata_b1, rdata_b0;
  logic [NR-1:0]     rbusy_b1, rbusy_b0;
  logic              iss_ready_b1, iss_ready_b0;
  logic              err_b1, err_b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf_m [NREG] = '{default: '0};
  int          pend_m [NREG] = '{default: 0};
  bit          err_m = 1'b0;

  always #5 clock = ~clock;

  ysyx_23060236_regfile_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1), .PEND_W(PW)
  ) u_b1 (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_b1), .rbusy(rbusy_b1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b1), .wen(wen),
    .waddr(waddr), .wdata(wdata), .flush(flush), .err(err_b1)
  );

  ysyx_23060236_regfile_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0), .PEND_W(PW)
  ) u_b0 (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_b0), .rbusy(rbusy_b0),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b0), .wen(wen),
    .waddr(waddr), .wdata(wdata), .flush(flush), .err(err_b0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue is refused only when the target is saturated and not retiring this cycle.
  function automatic bit model_ready();
    if (iss_valid && iss_rd != 0 && pend_m[iss_rd] == PMAX && !(wen && waddr == iss_rd))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pend_after(input int r);
    int p;
    int inc;
    int dec;
    if (r == 0 || reset || flush) return 0;
    p   = pend_m[r];
    inc = (iss_valid && model_ready() && iss_rd == r) ? 1 : 0;
    dec = (wen && waddr == r && p > 0) ? 1 : 0;
    return p + inc - dec;
  endfunction

  always @(posedge clock or posedge reset) begin
    int np [NREG];
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        rf_m[r]   = '0;
        pend_m[r] = 0;
      end
      err_m = 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) np[r] = pend_after(r);
      if (wen && waddr != 0 && pend_m[waddr] == 0) err_m = 1'b1;
      if (wen && waddr != 0) rf_m[waddr] = wdata;
      for (int r = 0; r < NREG; r++) pend_m[r] = np[r];
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NR; i++) begin
      int          a;
      logic [31:0] ed;
      logic [31:0] ed_byp;
      bit          eb;
      a      = int'(raddr[i*AW +: AW]);
      ed     = (a == 0) ? 32'h0 : rf_m[a];
      ed_byp = (a != 0 && wen && waddr == a) ? wdata : ed;
      eb     = (a != 0) && (pend_after(a) != 0);
      chk("rdata_byp", rdata_b1[i*DW +: DW], ed_byp);
      chk("rdata_nobyp", rdata_b0[i*DW +: DW], ed);
      chk("rbusy_byp", {31'b0, rbusy_b1[i]}, {31'b0, eb});
      chk("rbusy_nobyp", {31'b0, rbusy_b0[i]}, {31'b0, eb});
    end
    chk("iss_ready_byp", {31'b0, iss_ready_b1}, {31'b0, model_ready()});
    chk("iss_ready_nobyp", {31'b0, iss_ready_b0}, {31'b0, model_ready()});
    chk("err_byp", {31'b0, err_b1}, {31'b0, err_m});
    chk("err_nobyp", {31'b0, err_b0}, {31'b0, err_m});
  end

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle();
    raddr     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    flush     = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    go();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    go();
    go();
    reset = 1'b0;

    // Async reset mid-run after a write
    wen = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
    go();
    wen = 1'b0; raddr = {4'd0, 4'd5};
    mid();
    chk("rf5_written", rdata_b0[31:0], 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    chk("rst_rdata", rdata_b1[31:0], 32'h0);
    chk("rst_rbusy", {31'b0, rbusy_b1[0]}, 32'h0);
    chk("rst_iss_ready", {31'b0, iss_ready_b1}, 32'h1);
    chk("rst_err", {31'b0, err_b0}, 32'h0);
    go();
    reset = 1'b0;

    // Bypass versus array path
    wen = 1'b1; waddr = 4'd3; wdata = 32'h12345678; raddr = {4'd0, 4'd3};
    mid();
    chk("bypass_same_cycle", rdata_b1[31:0], 32'h12345678);
    chk("nobypass_old", rdata_b0[31:0], 32'h0);
    go();
    wen = 1'b0;
    mid();
    chk("nobypass_next", rdata_b0[31:0], 32'h12345678);
    go();
    reset_pulse();

    // Saturate register 7
    iss_valid = 1'b1; iss_rd = 4'd7; raddr = {4'd7, 4'd0};
    mid();
    chk("issue_busy_same_cycle", {31'b0, rbusy_b1[1]}, 32'h1);
    repeat (3) go();
    mid();
    chk("issue_full_stall", {31'b0, iss_ready_b1}, 32'h0);
    go();
    wen = 1'b1; waddr = 4'd7; wdata = 32'h77;
    mid();
    chk("issue_full_retire_ready", {31'b0, iss_ready_b0}, 32'h1);
    go();
    wen = 1'b0;
    mid();
    chk("count_stays_full", {31'b0, iss_ready_b1}, 32'h0);
    chk("count_full_busy", {31'b0, rbusy_b0[1]}, 32'h1);
    go();
    iss_valid = 1'b0; flush = 1'b1;
    go();
    flush = 1'b0;

    // Simultaneous issue and retire on register 4
    iss_valid = 1'b1; iss_rd = 4'd4;
    go();
    wen = 1'b1; waddr = 4'd4; wdata = 32'h44; raddr = {4'd0, 4'd4};
    mid();
    chk("inc_dec_busy", {31'b0, rbusy_b1[0]}, 32'h1);
    go();
    iss_valid = 1'b0;
    mid();
    chk("retire_clears_busy", {31'b0, rbusy_b1[0]}, 32'h0);
    go();
    idle();
    reset_pulse();

    // x0 is inert
    wen = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 4'd0;
    raddr = '0;
    mid();
    chk("x0_rdata", rdata_b1[31:0], 32'h0);
    chk("x0_rbusy", {31'b0, rbusy_b1[0]}, 32'h0);
    chk("x0_iss_ready", {31'b0, iss_ready_b1}, 32'h1);
    go();
    idle();
    mid();
    chk("x0_no_err", {31'b0, err_b1}, 32'h0);
    go();

    // Flush then orphan write-back
    iss_valid = 1'b1; iss_rd = 4'd2; raddr = {4'd0, 4'd2};
    go();
    go();
    iss_valid = 1'b0; flush = 1'b1;
    go();
    flush = 1'b0;
    mid();
    chk("flush_clears_busy", {31'b0, rbusy_b0[0]}, 32'h0);
    go();
    wen = 1'b1; waddr = 4'd2; wdata = 32'hA5A5A5A5;
    go();
    wen = 1'b0;
    mid();
    chk("orphan_err", {31'b0, err_b1}, 32'h1);
    chk("orphan_data", rdata_b0[31:0], 32'hA5A5A5A5);
    repeat (5) go();
    mid();
    chk("err_sticky", {31'b0, err_b0}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("err_reset", {31'b0, err_b1}, 32'h0);
    go();
    reset = 1'b0;

    // Randomized traffic on a narrow register window to force collisions
    repeat (3000) begin
      raddr     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      iss_valid = ($urandom % 2) == 0;
      iss_rd    = 4'($urandom_range(0, 7));
      wen       = ($urandom % 3) == 0;
      waddr     = 4'($urandom_range(0, 7));
      wdata     = $urandom;
      flush     = ($urandom % 40) == 0;
      reset     = ($urandom % 300) == 0;
      go();
    end
    idle();
    reset = 1'b0;
    go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
